fifo_word_packer: RTL

Downstream consumer of the 8-bit byte FIFO. Pops bytes through the FIFO read handshake and packs BYTES consecutive bytes into one word, least-significant byte first. Presents the word on a valid/ready output port. Partial words go out on an explicit flush or after an idle timeout, with a byte-keep mask marking the valid lanes.

---
 rtl/fifo_word_packer.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_word_packer.sv
// Byte-to-word packer behind a show-ahead byte FIFO: LSB-first packing, valid/ready output,
// partial words released by flush or idle timeout with a lane keep mask.
module fifo_word_packer #(
  parameter int DATA_W  = 8,
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fifo_rd_val,
  input  logic [DATA_W-1:0]         fifo_rd_data,
  output logic                      fifo_rd_en,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W*BYTES-1:0]   out_data,
  output logic [BYTES-1:0]          out_keep
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WW = DATA_W * BYTES;

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [TW-1:0]   timer_reg;
  logic [WW-1:0]   lane_reg;
  logic [WW-1:0]   data_reg;
  logic [BYTES-1:0] keep_reg;
  logic            valid_reg;

  logic            pop;
  logic [CW-1:0]   count_next;
  logic [WW-1:0]   lane_next;
  logic [BYTES-1:0] keep_next;
  logic [TW-1:0]   timer_next;
  logic            timeout_hit;
  logic            do_flush;
  logic            emit;

  // In HOLD a pop is only allowed on the accepting edge, so a byte never lands in a held word.
  assign pop        = fifo_rd_val & ((state_reg == FILL) | out_ready);
  assign fifo_rd_en = pop;
  assign count_next = count_reg + CW'(pop);

  // lane_reg is cleared whenever a word leaves, so lanes above count are always zero.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane_next[gi*DATA_W +: DATA_W] = (pop && (count_reg == CW'(gi))) ?
                                              fifo_rd_data : lane_reg[gi*DATA_W +: DATA_W];
      assign keep_next[gi] = (CW'(gi) < count_next);
    end
    if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (state_reg == FILL) && (timer_reg == TW'(TIMEOUT));
      assign timer_next  = (pop || (count_next == '0)) ? '0 : timer_reg + TW'(1);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
      assign timer_next  = '0;
    end
  endgenerate

  assign do_flush = flush | timeout_hit;
  assign emit     = (state_reg == FILL) &&
                    ((count_next == CW'(BYTES)) || (do_flush && (count_next != '0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FILL;
      count_reg <= '0;
      timer_reg <= '0;
      lane_reg  <= '0;
      data_reg  <= '0;
      keep_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (emit) begin
            state_reg <= HOLD;
            valid_reg <= 1'b1;
            data_reg  <= lane_next;
            keep_reg  <= keep_next;
            lane_reg  <= '0;
            count_reg <= '0;
            timer_reg <= '0;
          end else begin
            lane_reg  <= lane_next;
            count_reg <= count_next;
            timer_reg <= timer_next;
          end
        end
        HOLD: begin
          if (out_ready) begin
            // A coinciding pop starts the next word in lane 0 with no bubble.
            state_reg <= FILL;
            valid_reg <= 1'b0;
            lane_reg  <= lane_next;
            count_reg <= count_next;
            timer_reg <= '0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_keep  = keep_reg;

endmodule
